// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, issues one imem read at a time and hands
// {inst, pc} to decode over valid/ready. Supports redirects and a sticky halt.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_REQ,
    S_WAIT,
    S_OUT,
    S_DROP,
    S_HALT
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        halt_latch;
  logic        halt_now;
  logic        capture;
  logic [31:0] redirect_target;

  assign halt_now        = halt_latch | halt;
  assign redirect_target = {redirect_pc[31:2], 2'b00};

  // Outputs are forced low while rst is held so nothing leaks out of a stale state.
  assign imem_req_valid = !rst && (state == S_REQ) && !halt_now;
  assign imem_req_addr  = pc;
  assign out_valid      = !rst && (state == S_OUT);
  assign halted         = !rst && (state == S_HALT);

  always_comb begin
    state_next = state;
    pc_next    = pc;
    capture    = 1'b0;
    case (state)
      S_REQ: begin
        if (halt_now) begin
          state_next = S_HALT;
        end else if (redirect_valid) begin
          pc_next = redirect_target;
          // The request at the old pc was accepted; its response must be thrown away.
          if (imem_req_ready) state_next = S_DROP;
        end else if (imem_req_ready) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_next    = redirect_target;
          state_next = imem_resp_valid ? S_REQ : S_DROP;
        end else if (imem_resp_valid) begin
          capture    = 1'b1;
          state_next = S_OUT;
        end
      end
      S_DROP: begin
        if (redirect_valid) pc_next = redirect_target;
        if (imem_resp_valid) state_next = S_REQ;
      end
      S_OUT: begin
        // Redirect squashes the held instruction even if decode is ready.
        if (redirect_valid) begin
          pc_next    = redirect_target;
          state_next = S_REQ;
        end else if (out_ready) begin
          pc_next    = pc + 32'd4;
          state_next = S_REQ;
        end
      end
      S_HALT: begin
        state_next = S_HALT;
      end
      default: begin
        state_next = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      halt_latch <= 1'b0;
      out_inst   <= 32'h0;
      out_pc     <= 32'h0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (halt) halt_latch <= 1'b1;
      if (capture) begin
        out_inst <= imem_resp_data;
        out_pc   <= pc;
      end
    end
  end

endmodule
